// File: rtl/dsb_pkg.sv
// Shared types and helpers for the destination decoder / outstanding-write scoreboard.
package dsb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 2;
  localparam int DEF_NREGS  = 1 << DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  function automatic logic [DEF_NREGS-1:0] onehot(input reg_addr_t addr);
    onehot       = '0;
    onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/dest_decode_scoreboard_if.sv
// Decode-stage issue, write-back and scoreboard status bundle for dest_decode_scoreboard.
interface dest_decode_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int NREGS  = 1 << ADDR_W
);
  // Issue handshake: issue_valid offers an instruction; it is accepted on a rising
  // edge only when issue_fire (= issue_valid & ~stall) is high; otherwise decode holds it.
  logic              issue_valid;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_dst;
  logic              src0_vld;
  logic [ADDR_W-1:0] src0_addr;
  logic              src1_vld;
  logic [ADDR_W-1:0] src1_addr;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dst;
  logic              flush;
  logic [NREGS-1:0]  wb_we_onehot;
  logic              stall;
  logic              issue_fire;
  logic [NREGS-1:0]  pending_vec;
  logic              err_underflow;

  modport master (
    output issue_valid, issue_we, issue_dst, src0_vld, src0_addr, src1_vld, src1_addr,
           wb_valid, wb_dst, flush,
    input  wb_we_onehot, stall, issue_fire, pending_vec, err_underflow
  );

  modport slave (
    input  issue_valid, issue_we, issue_dst, src0_vld, src0_addr, src1_vld, src1_addr,
           wb_valid, wb_dst, flush,
    output wb_we_onehot, stall, issue_fire, pending_vec, err_underflow
  );
endinterface

// File: rtl/onehot_decoder.sv
// Combinational address to one-hot decoder with enable.
module onehot_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  output logic [(1<<ADDR_W)-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[addr] = 1'b1;
  end

endmodule

// File: rtl/dest_decode_scoreboard.sv
// Write-back one-hot decoder plus per-register outstanding-write counters and decode stall.
// Optional build macro SCOREBOARD_BYPASS_EN: a source whose last pending write is
// retiring this cycle is forwarded instead of stalling.
module dest_decode_scoreboard
  import dsb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREGS    = 1 << ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int ZERO_REG = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  dest_decode_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NREGS-1:0]            wb_hot;
  logic [NREGS-1:0]            iss_hot;
  logic [NREGS-1:0]            zmask;
  logic [NREGS-1:0]            inc;
  logic [NREGS-1:0]            dec;
  logic [NREGS-1:0]            uf;
  logic [NREGS-1:0]            pend;
  logic [NREGS-1:0][CNT_W-1:0] cnt_all;
  logic [CNT_W-1:0]            src0_cnt;
  logic [CNT_W-1:0]            src1_cnt;
  logic [CNT_W-1:0]            dst_cnt;
  logic                        haz_s0;
  logic                        haz_s1;
  logic                        haz_d;
  logic                        byp0;
  logic                        byp1;
  logic                        stall;
  logic                        fire;
  logic                        err_q;

  onehot_decoder #(.ADDR_W(ADDR_W)) u_wb_dec (
    .en   (bus.wb_valid),
    .addr (bus.wb_dst),
    .dec  (wb_hot)
  );

  onehot_decoder #(.ADDR_W(ADDR_W)) u_iss_dec (
    .en   (bus.issue_we),
    .addr (bus.issue_dst),
    .dec  (iss_hot)
  );

  // A hardwired register 0 is masked out of both the write enable and the counters.
  assign zmask = (ZERO_REG != 0) ? ~NREGS'(onehot(reg_addr_t'(0))) : {NREGS{1'b1}};

  assign dec              = wb_hot & zmask;
  assign bus.wb_we_onehot = dec;

  assign src0_cnt = cnt_all[bus.src0_addr];
  assign src1_cnt = cnt_all[bus.src1_addr];
  assign dst_cnt  = cnt_all[bus.issue_dst];

`ifdef SCOREBOARD_BYPASS_EN
  assign byp0 = bus.wb_valid && (bus.wb_dst == bus.src0_addr) && (src0_cnt == CNT_ONE);
  assign byp1 = bus.wb_valid && (bus.wb_dst == bus.src1_addr) && (src1_cnt == CNT_ONE);
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  assign haz_s0 = bus.src0_vld && (src0_cnt != '0) && !byp0;
  assign haz_s1 = bus.src1_vld && (src1_cnt != '0) && !byp1;
  assign haz_d  = bus.issue_we && (dst_cnt == CNT_MAX);

  assign stall = bus.issue_valid & (haz_s0 | haz_s1 | haz_d);
  assign fire  = bus.issue_valid & ~stall;
  assign inc   = iss_hot & zmask & {NREGS{fire}};

  assign bus.stall      = stall;
  assign bus.issue_fire = fire;

  for (genvar r = 0; r < NREGS; r++) begin : gen_reg
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (bus.flush) begin
        cnt <= '0;
      end else if (inc[r] && !dec[r]) begin
        cnt <= cnt + CNT_ONE;
      end else if (dec[r] && !inc[r] && (cnt != '0)) begin
        cnt <= cnt - CNT_ONE;
      end
    end

    assign cnt_all[r] = cnt;
    assign pend[r]    = (cnt != '0);
    assign uf[r]      = dec[r] && !inc[r] && (cnt == '0);
  end

  assign bus.pending_vec = pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (|uf) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_dest_decode_scoreboard.sv
// Directed bench for dest_decode_scoreboard: one ZERO_REG=0 instance and one ZERO_REG=1 instance.
module tb_dest_decode_scoreboard;
  import dsb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic exp_byp_stall;

  dest_decode_scoreboard_if #(.ADDR_W(5)) ifa ();
  dest_decode_scoreboard_if #(.ADDR_W(5)) ifb ();

  dest_decode_scoreboard #(.ADDR_W(5), .CNT_W(2), .ZERO_REG(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  dest_decode_scoreboard #(.ADDR_W(5), .CNT_W(2), .ZERO_REG(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_a(input logic iv, input logic we, input reg_addr_t dst,
                         input logic s0v, input reg_addr_t s0,
                         input logic wv, input reg_addr_t wd, input logic fl);
    ifa.issue_valid = iv;
    ifa.issue_we    = we;
    ifa.issue_dst   = dst;
    ifa.src0_vld    = s0v;
    ifa.src0_addr   = s0;
    ifa.src1_vld    = 1'b0;
    ifa.src1_addr   = '0;
    ifa.wb_valid    = wv;
    ifa.wb_dst      = wd;
    ifa.flush       = fl;
  endtask

  task automatic drive_b(input logic iv, input logic we, input reg_addr_t dst,
                         input logic s0v, input reg_addr_t s0,
                         input logic wv, input reg_addr_t wd, input logic fl);
    ifb.issue_valid = iv;
    ifb.issue_we    = we;
    ifb.issue_dst   = dst;
    ifb.src0_vld    = s0v;
    ifb.src0_addr   = s0;
    ifb.src1_vld    = 1'b0;
    ifb.src1_addr   = '0;
    ifb.wb_valid    = wv;
    ifb.wb_dst      = wd;
    ifb.flush       = fl;
  endtask

  // comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef SCOREBOARD_BYPASS_EN
    exp_byp_stall = 1'b0;
`else
    exp_byp_stall = 1'b1;
`endif
    rst_n = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // reset state; combinational decode follows inputs even in reset
    check("rst_pending", ifa.pending_vec, 32'h0);
    check("rst_err", {31'h0, ifa.err_underflow}, 32'h0);
    check("rst_stall", {31'h0, ifa.stall}, 32'h0);
    drive_a(0, 0, 0, 0, 0, 1, 5'd12, 0);
    settle();
    check("rst_wb_onehot", ifa.wb_we_onehot, 32'h0000_1000);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // RAW hazard on reg 5
    drive_a(1, 1, 5'd5, 0, 0, 0, 0, 0);
    settle();
    check("t2_issue_fire", {31'h0, ifa.issue_fire}, 32'h1);
    tick();
    check("t2_pending5", ifa.pending_vec, 32'h0000_0020);
    drive_a(1, 0, 0, 1, 5'd5, 0, 0, 0);
    ifa.src1_vld  = 1'b1;
    ifa.src1_addr = 5'd6;
    settle();
    check("t2_stall_c1", {31'h0, ifa.stall}, 32'h1);
    check("t2_fire_c1", {31'h0, ifa.issue_fire}, 32'h0);
    tick();
    check("t2_stall_c2", {31'h0, ifa.stall}, 32'h1);
    ifa.wb_valid = 1'b1;
    ifa.wb_dst   = 5'd5;
    settle();
    check("t2_wb_onehot", ifa.wb_we_onehot, 32'h0000_0020);
    check("t2_stall_wb", {31'h0, ifa.stall}, {31'h0, exp_byp_stall});
    tick();
    ifa.wb_valid = 1'b0;
    settle();
    check("t2_stall_after", {31'h0, ifa.stall}, 32'h0);
    check("t2_pending_clr", ifa.pending_vec, 32'h0);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // fill reg 7 to max
    drive_a(1, 1, 5'd7, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("t3_stall_max", {31'h0, ifa.stall}, 32'h1);
    check("t3_pending7", ifa.pending_vec, 32'h0000_0080);
    ifa.wb_valid = 1'b1;
    ifa.wb_dst   = 5'd7;
    settle();
    check("t3_stall_wbcyc", {31'h0, ifa.stall}, 32'h1);
    tick();
    ifa.wb_valid = 1'b0;
    settle();
    check("t3_fire_after_wb", {31'h0, ifa.issue_fire}, 32'h1);
    tick();
    drive_a(0, 0, 0, 0, 0, 1, 5'd7, 0);
    repeat (3) tick();
    check("t3_drained", ifa.pending_vec, 32'h0);
    check("t3_no_err", {31'h0, ifa.err_underflow}, 32'h0);

    // simultaneous inc/dec on reg 9
    drive_a(1, 1, 5'd9, 0, 0, 0, 0, 0);
    tick();
    drive_a(1, 1, 5'd9, 0, 0, 1, 5'd9, 0);
    settle();
    check("t4_fire", {31'h0, ifa.issue_fire}, 32'h1);
    tick();
    check("t4_pending9", ifa.pending_vec, 32'h0000_0200);
    drive_a(0, 0, 0, 0, 0, 1, 5'd9, 0);
    tick();
    check("t4_pending_clr", ifa.pending_vec, 32'h0);
    check("t4_no_err", {31'h0, ifa.err_underflow}, 32'h0);

    // reg 0 is tracked when not hardwired
    drive_a(1, 1, 5'd0, 0, 0, 0, 0, 0);
    tick();
    check("z0_pending0", ifa.pending_vec, 32'h0000_0001);
    drive_a(0, 0, 0, 1, 5'd0, 1, 5'd0, 0);
    settle();
    check("z0_wb_onehot", ifa.wb_we_onehot, 32'h0000_0001);
    tick();
    check("z0_pending_clr", ifa.pending_vec, 32'h0);

    // underflow on reg 12
    drive_a(0, 0, 0, 0, 0, 1, 5'd12, 0);
    settle();
    check("t5_wb_onehot", ifa.wb_we_onehot, 32'h0000_1000);
    check("t5_err_before", {31'h0, ifa.err_underflow}, 32'h0);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("t5_err_set", {31'h0, ifa.err_underflow}, 32'h1);
    check("t5_pending", ifa.pending_vec, 32'h0);
    tick();
    check("t5_err_hold", {31'h0, ifa.err_underflow}, 32'h1);

    // asynchronous reset mid-run with cnt[3]=2
    drive_a(1, 1, 5'd3, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check("t1_pending3", ifa.pending_vec, 32'h0000_0008);
    drive_a(1, 0, 0, 1, 5'd3, 0, 0, 0);
    settle();
    check("t1_stall_pre", {31'h0, ifa.stall}, 32'h1);
    rst_n = 1'b0;
    settle();
    check("t1_pending_async", ifa.pending_vec, 32'h0);
    check("t1_err_async", {31'h0, ifa.err_underflow}, 32'h0);
    check("t1_stall_async", {31'h0, ifa.stall}, 32'h0);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // flush clears pending regs 2 and 4; later write-back underflows
    drive_a(1, 1, 5'd2, 0, 0, 0, 0, 0);
    tick();
    drive_a(1, 1, 5'd4, 0, 0, 0, 0, 0);
    tick();
    check("fl_pending", ifa.pending_vec, 32'h0000_0014);
    drive_a(1, 1, 5'd4, 0, 0, 1, 5'd2, 1);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("fl_pending_clr", ifa.pending_vec, 32'h0);
    check("fl_err_clean", {31'h0, ifa.err_underflow}, 32'h0);
    drive_a(0, 0, 0, 0, 0, 1, 5'd2, 0);
    tick();
    check("fl_late_wb_err", {31'h0, ifa.err_underflow}, 32'h1);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);

    // hardwired register 0 instance
    drive_b(1, 1, 5'd0, 0, 0, 0, 0, 0);
    settle();
    check("t6_fire0", {31'h0, ifb.issue_fire}, 32'h1);
    tick();
    check("t6_pending0", ifb.pending_vec, 32'h0);
    drive_b(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0);
    settle();
    check("t6_stall0", {31'h0, ifb.stall}, 32'h0);
    check("t6_wb_onehot0", ifb.wb_we_onehot, 32'h0);
    tick();
    check("t6_err0", {31'h0, ifb.err_underflow}, 32'h0);
    drive_b(1, 1, 5'd2, 0, 0, 0, 0, 0);
    tick();
    drive_b(1, 1, 5'd4, 0, 0, 0, 0, 0);
    tick();
    check("t6_pending24", ifb.pending_vec, 32'h0000_0014);
    drive_b(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("t6_flush_clr", ifb.pending_vec, 32'h0);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
